sevenseg_scan_n: RTL and testbench

- Parametrised N-digit, time-multiplexed seven-segment driver. Next generation of the fixed 4-digit mux.
- Has an internal scan prescaler, an atomic digit load, per-digit decimal points, optional leading-zero blanking, and a one-cycle anti-ghosting dead time.
- Sits between game logic (shot clock and score) and the board's common-anode display pins (an, seg, dp all active-low).

---
 rtl/sevenseg_scan_n.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_n.sv
// N-digit time-multiplexed common-anode seven-segment driver with prescaler, atomic shadow load,
// leading-zero blanking and a one-cycle dead slot. Optional PWM dimming: SEVENSEG_BRIGHTNESS_PWM_EN.
module sevenseg_scan_n #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
  input  logic [3:0]              brightness,
`endif
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_blz;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dpn;

  logic                    w_tc;
  logic [3:0]              w_cur;
  logic [NUM_DIGITS-1:0]   w_blank_vec;
  logic                    w_zero_run;
  logic                    w_blank;
  logic [6:0]              w_seg;
  logic                    w_dpn;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_pwm_on;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // A digit is blanked when it and every digit to its left are zero; digit 0 never is.
  always_comb begin
    w_zero_run  = 1'b1;
    w_blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run     = w_zero_run & (r_dig[4*k +: 4] == 4'h0);
      w_blank_vec[k] = w_zero_run;
    end
  end

  assign w_tc     = (r_pre == PW'(SCAN_DIV - 1));
  assign w_cur    = r_dig[{r_idx, 2'b00} +: 4];
  assign w_blank  = r_blz & w_blank_vec[r_idx];
  assign w_seg    = w_blank ? 7'h7F : decode(w_cur);
  assign w_dpn    = w_blank | ~r_dp[r_idx];
  assign w_onehot = NUM_DIGITS'(1) << r_idx;

`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
  logic [3:0] r_pwm;
  logic [3:0] r_bri;

  assign w_pwm_on = (r_pwm <= r_bri);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 4'h0;
      r_bri <= 4'hF;
    end else begin
      r_pwm <= r_pwm + 4'h1;
      if (load) r_bri <= brightness;
    end
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  // The advance edge blanks all anodes so the old segments never ghost onto the next digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_dig <= '1;
      r_dp  <= '0;
      r_blz <= 1'b0;
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dpn <= 1'b1;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + 1'b1;
      if (w_tc) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_dig <= digits;
        r_dp  <= dp_in;
        r_blz <= blank_lz;
      end
      r_an  <= (w_tc || !w_pwm_on) ? '1 : ~w_onehot;
      r_seg <= w_seg;
      r_dpn <= w_dpn;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp_n = r_dpn;
endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Bench for sevenseg_scan_n (4 digits, 4 cycles per slot) against a cycle-count based model.
module tb_sevenseg_scan_n;
  localparam int N = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [4*N-1:0] digits;
  logic [N-1:0] dp_in;
  logic         blank_lz;
  logic [3:0]   brightness;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp_n;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  sevenseg_scan_n #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .clk(clk), .rst(rst), .load(load), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: position in the scan is pure arithmetic on edges since reset.
  int           m_t;
  logic [3:0]   m_dig [N];
  logic [N-1:0] m_dp;
  logic         m_blz;
  logic [3:0]   m_bri;
  logic [N-1:0] exp_an;
  logic [6:0]   exp_seg;
  logic         exp_dpn;
  bit           exp_lit;

  always @(posedge clk) begin
    int pre, idx, hi;
    bit blank;
    if (rst) begin
      m_t = 0;
      for (int j = 0; j < N; j++) m_dig[j] = 4'hF;
      m_dp = '0; m_blz = 1'b0; m_bri = 4'hF;
      exp_an = '1; exp_seg = 7'h7F; exp_dpn = 1'b1; exp_lit = 1'b1;
    end else begin
      pre = m_t % S;
      idx = (m_t / S) % N;
      hi = -1;
      for (int j = 0; j < N; j++) if (m_dig[j] != 4'h0) hi = j;
      blank = m_blz && idx > 0 && idx > hi;
      exp_lit = (pre != S - 1);
      exp_an  = exp_lit ? ~(N'(1) << idx) : '1;
`ifdef SEVENSEG_BRIGHTNESS_PWM_EN
      if ((m_t % 16) > m_bri) exp_an = '1;
`endif
      exp_seg = blank ? 7'h7F : seg_of(m_dig[idx]);
      exp_dpn = blank ? 1'b1 : ~m_dp[idx];
      if (load) begin
        for (int j = 0; j < N; j++) m_dig[j] = digits[4*j +: 4];
        m_dp = dp_in; m_blz = blank_lz; m_bri = brightness;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", 32'(an), 32'(exp_an));
      if (exp_lit) begin
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp_n", 32'(dp_n), 32'(exp_dpn));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [N-1:0] dp, input logic blz);
    load = 1'b1; digits = d; dp_in = dp; blank_lz = blz;
    cycles(1);
    load = 1'b0;
  endtask

  // Bounded wait until the next edge is an index-advance edge.
  task automatic wait_adv_edge();
    int k;
    k = 0;
    while ((m_t % S) != S - 1 && k < 2 * S) begin
      cycles(1);
      k++;
    end
    chk("adv_wait_bound", 32'(k < 2 * S), 32'd1);
  endtask

  initial begin
    logic [3:0] tens, ones;
    logic [15:0] rd;
    rst = 1'b1; load = 1'b0; digits = '0; dp_in = '0; blank_lz = 1'b0; brightness = 4'hF;
    @(posedge clk);
    chk_en = 1'b1;
    cycles(5);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dpn", 32'(dp_n), 32'd1);

    // First unreset edge loads 0010; that edge still shows the blank reset shadow.
    rst = 1'b0;
    do_load(16'h0010, 4'b0000, 1'b0);
    cycles(1);
    chk("lit_d0_an", 32'(an), 32'b1110);
    chk("lit_d0_seg", 32'(seg), 32'b1000000);
    cycles(2);
    chk("lit_dead_an", 32'(an), 32'hF);
    cycles(1);
    chk("lit_d1_an", 32'(an), 32'b1101);
    chk("lit_d1_seg", 32'(seg), 32'b1111001);
    cycles(12);
    chk("lit_wrap_an", 32'(an), 32'b1110);
    cycles(16);

    do_load(16'h0010, 4'b0000, 1'b1);
    cycles(20);
    do_load(16'h0000, 4'b1111, 1'b1);
    cycles(20);
    do_load(16'hF000, 4'b0000, 1'b1);
    cycles(16);

    for (int v = 10; v >= 0; v--) begin
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      if (v % 3 == 0) wait_adv_edge();
      do_load({8'h00, tens, ones}, 4'b0000, 1'b0);
      cycles(15);
    end

    do_load(16'h1234, 4'b0100, 1'b0);
    cycles(34);
    rst = 1'b1;
    cycles(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    cycles(8);

    for (int c = 0; c < 500; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < N; j++)
        rd[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      digits = rd;
      dp_in = N'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      brightness = 4'($urandom_range(0, 15));
      cycles(1);
    end
    rst = 1'b0; load = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
